// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetcher and mem_ctrler.
// Hits answer on the next edge; misses run a REQ/WAIT/FILL handshake with mem_ctrler.
module icache #(
    parameter int INDEX_WIDTH    = 8,
    parameter int MEM_DATA_DELAY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [31:0] addr_from_fetcher,
    input  logic        valid_from_fetcher,
    input  logic        flush_from_rob,
    output logic        busy_to_fetcher,
    output logic        ready_to_fetcher,
    output logic [31:0] data_to_fetcher,
    output logic [31:0] addr_to_mem,
    output logic        valid_to_mem,
    input  logic        ready_from_mem,
    input  logic [31:0] data_from_mem
);

    localparam int LINES = 1 << INDEX_WIDTH;
    localparam int TAG_W = 30 - INDEX_WIDTH;
    localparam int CNT_W = $clog2(MEM_DATA_DELAY + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        maddr_q, maddr_d;
    logic               mvalid_q, mvalid_d;
    logic               flushed_q, flushed_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [INDEX_WIDTH-1:0] f_idx, fill_idx;
    logic [TAG_W-1:0]       f_tag, fill_tag;
    logic                   hit, fill_we;
    logic                   unused_ok;

    assign f_idx    = addr_from_fetcher[INDEX_WIDTH+1:2];
    assign f_tag    = addr_from_fetcher[31:INDEX_WIDTH+2];
    assign fill_idx = maddr_q[INDEX_WIDTH+1:2];
    assign fill_tag = maddr_q[31:INDEX_WIDTH+2];
    assign hit      = valid_q[f_idx] && (tag_mem[f_idx] == f_tag);
    assign unused_ok = &{1'b0, addr_from_fetcher[1:0], maddr_q[1:0]};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        ready_d   = 1'b0;
        data_d    = data_q;
        maddr_d   = maddr_q;
        mvalid_d  = mvalid_q;
        flushed_d = flushed_q;
        valid_d   = valid_q;
        fill_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                flushed_d = 1'b0;
                if (valid_from_fetcher) begin
                    if (hit) begin
                        if (!flush_from_rob) begin
                            ready_d = 1'b1;
                            data_d  = data_mem[f_idx];
                        end
                    end else begin
                        maddr_d   = {addr_from_fetcher[31:2], 2'b00};
                        mvalid_d  = 1'b1;
                        busy_d    = 1'b1;
                        flushed_d = flush_from_rob;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (flush_from_rob) flushed_d = 1'b1;
                // mem_ctrler streams from addr_to_mem until it accepts, so hold until then
                if (ready_from_mem) begin
                    mvalid_d = 1'b0;
                    cnt_d    = CNT_W'(MEM_DATA_DELAY - 1);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (flush_from_rob) flushed_d = 1'b1;
                if (cnt_q == '0) state_d = FILL;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FILL: begin
                fill_we            = 1'b1;
                valid_d[fill_idx]  = 1'b1;
                if (!(flushed_q || flush_from_rob)) begin
                    ready_d = 1'b1;
                    data_d  = data_from_mem;
                end
                busy_d    = 1'b0;
                flushed_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            data_q    <= '0;
            maddr_q   <= '0;
            mvalid_q  <= 1'b0;
            flushed_q <= 1'b0;
            valid_q   <= '0;
        end else if (rdy) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            data_q    <= data_d;
            maddr_q   <= maddr_d;
            mvalid_q  <= mvalid_d;
            flushed_q <= flushed_d;
            valid_q   <= valid_d;
        end
    end

    // Tag/data storage carries no reset; the valid vector guards it.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= data_from_mem;
        end
    end

    assign busy_to_fetcher  = busy_q;
    assign ready_to_fetcher = ready_q;
    assign data_to_fetcher  = data_q;
    assign addr_to_mem      = maddr_q;
    assign valid_to_mem     = mvalid_q;

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus random fetches against a line-map reference model.
module tb_icache;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [31:0] addr_from_fetcher = '0;
    logic        valid_from_fetcher = 1'b0;
    logic        flush_from_rob = 1'b0;
    logic        busy_to_fetcher, ready_to_fetcher, valid_to_mem;
    logic [31:0] data_to_fetcher, addr_to_mem;
    logic        ready_from_mem = 1'b0;
    logic [31:0] data_from_mem = '0;

    int total = 0;
    int bad   = 0;

    // Reference model: which word address each line holds and its contents.
    bit          mv    [256];
    logic [29:0] mline [256];
    logic [31:0] mdata [256];

    icache #(.INDEX_WIDTH(8), .MEM_DATA_DELAY(D)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .addr_from_fetcher(addr_from_fetcher), .valid_from_fetcher(valid_from_fetcher),
        .flush_from_rob(flush_from_rob), .busy_to_fetcher(busy_to_fetcher),
        .ready_to_fetcher(ready_to_fetcher), .data_to_fetcher(data_to_fetcher),
        .addr_to_mem(addr_to_mem), .valid_to_mem(valid_to_mem),
        .ready_from_mem(ready_from_mem), .data_from_mem(data_from_mem)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
    endtask

    // One fetch from IDLE. req = REQ cycles before mem accepts; poke = extra request in REQ;
    // flw = flush in WAIT; stall = rdy-low cycles in WAIT; rab = reset mid-miss.
    task automatic fetch(input logic [31:0] a, input int req, input bit poke, input bit flw,
                         input int stall, input bit rab, input logic [31:0] word);
        logic [31:0] aw;
        int idx, lat, sl, e;
        bit hit, got, ended;
        aw  = {a[31:2], 2'b00};
        idx = int'(a[9:2]);
        hit = mv[idx] && (mline[idx] == a[31:2]);
        addr_from_fetcher  = a;
        valid_from_fetcher = 1'b1;
        @(negedge clk);
        valid_from_fetcher = 1'b0;
        if (hit) begin
            chk("hit_rdy",  ready_to_fetcher, 1);
            chk("hit_data", data_to_fetcher, mdata[idx]);
            chk("hit_busy", busy_to_fetcher, 0);
            chk("hit_v2m",  valid_to_mem, 0);
            @(negedge clk);
            chk("hit_once", ready_to_fetcher, 0);
            return;
        end
        chk("miss_busy",  busy_to_fetcher, 1);
        chk("miss_v2m",   valid_to_mem, 1);
        chk("miss_addr",  addr_to_mem, aw);
        chk("miss_nordy", ready_to_fetcher, 0);
        lat = 0;
        for (int k = 1; k <= req; k++) begin
            chk("req_v2m",  valid_to_mem, 1);
            chk("req_addr", addr_to_mem, aw);
            if (poke && k == 1) begin
                valid_from_fetcher = 1'b1;
                addr_from_fetcher  = a ^ 32'h40;
            end
            if (k == req) ready_from_mem = 1'b1;
            @(negedge clk);
            lat++;
            valid_from_fetcher = 1'b0;
            ready_from_mem     = 1'b0;
        end
        data_from_mem = {16'hBAD0, a[15:0]};
        chk("wait_v2m", valid_to_mem, 0);
        got = 0; ended = 0; sl = 0; e = 0;
        for (int t = 0; t < 40; t++) begin
            if (ready_to_fetcher) begin got = 1; break; end
            if (!busy_to_fetcher) begin ended = 1; break; end
            chk("wait_addr", addr_to_mem, aw);
            if (rab && t == 1) begin
                rst = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst = 1'b1;
                model_reset();
                return;
            end
            if (e == D) data_from_mem = word;
            flush_from_rob = flw && (t == 0);
            if (t == 0 && stall > 0) begin
                rdy = 1'b0;
                sl  = stall;
            end else if (sl > 0) begin
                sl--;
                if (sl == 0) rdy = 1'b1;
            end
            @(negedge clk);
            lat++;
            e++;
        end
        flush_from_rob = 1'b0;
        rdy = 1'b1;
        if (flw) begin
            chk("flush_nordy", got, 0);
            chk("flush_end",   ended, 1);
            chk("flush_lat",   lat, req + D + 1 + stall);
        end else begin
            chk("fill_rdy",  got, 1);
            chk("fill_data", data_to_fetcher, word);
            chk("miss_lat",  lat, req + D + 1 + stall);
            chk("fill_busy", busy_to_fetcher, 0);
        end
        mv[idx]    = 1'b1;
        mline[idx] = a[31:2];
        mdata[idx] = word;
        @(negedge clk);
        chk("fill_once", ready_to_fetcher, 0);
    endtask

    initial begin
        logic [31:0] a;
        int mode;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_to_fetcher, 0);
        chk("rst_rdy",  ready_to_fetcher, 0);
        chk("rst_data", data_to_fetcher, 0);
        chk("rst_addr", addr_to_mem, 0);
        chk("rst_v2m",  valid_to_mem, 0);
        rst = 1'b1;
        @(negedge clk);

        fetch(32'h100, 1, 0, 0, 0, 0, mfn(32'h100));
        fetch(32'h1004, 2, 0, 0, 0, 0, 32'hDEADBEEF);

        // back-to-back hits, [1:0] ignored
        addr_from_fetcher = 32'h1004; valid_from_fetcher = 1'b1;
        @(negedge clk);
        chk("b2b_rdy0",  ready_to_fetcher, 1);
        chk("b2b_data0", data_to_fetcher, 32'hDEADBEEF);
        addr_from_fetcher = 32'h1006;
        @(negedge clk);
        valid_from_fetcher = 1'b0;
        chk("b2b_rdy1",  ready_to_fetcher, 1);
        chk("b2b_data1", data_to_fetcher, 32'hDEADBEEF);
        chk("b2b_v2m",   valid_to_mem, 0);
        @(negedge clk);
        chk("b2b_end",   ready_to_fetcher, 0);

        // conflict on index 0
        fetch(32'h0000, 1, 0, 0, 0, 0, 32'h11111111);
        fetch(32'h0400, 2, 0, 0, 0, 0, 32'h22222222);
        fetch(32'h0000, 1, 0, 0, 0, 0, 32'h11111111);

        // flush mid-miss, then the filled line must hit
        fetch(32'h2000, 2, 0, 1, 0, 0, 32'hCAFEF00D);
        fetch(32'h2000, 1, 0, 0, 0, 0, 32'hCAFEF00D);

        // request ignored while busy, and a 4-cycle rdy stall in WAIT
        fetch(32'h3000, 3, 1, 0, 4, 0, 32'h0BADCAFE);
        fetch(32'h3040, 1, 0, 0, 0, 0, 32'h30403040);

        // reset mid-miss: both the aborted address and an old line must miss afterwards
        fetch(32'h5000, 2, 0, 0, 0, 1, 32'h55555555);
        @(negedge clk);
        fetch(32'h5000, 1, 0, 0, 0, 0, 32'h55555555);
        fetch(32'h1004, 1, 0, 0, 0, 0, 32'hDEADBEEF);

        for (int n = 0; n < 60; n++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
                | 32'($urandom_range(0, 3));
            mode = int'($urandom_range(0, 5));
            fetch(a, int'($urandom_range(1, 4)), mode == 1, mode == 2,
                  (mode == 3) ? int'($urandom_range(1, 3)) : 0, 0, mfn({a[31:2], 2'b00}));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
